// File: rtl/wishbone_master_bridge.sv
// Valid/ready request to single Wishbone classic cycle bridge, one transaction in flight,
// with a bus-timeout abort for unmapped or dead slaves.
module wishbone_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_sel,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // wishbone master
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_mosi,
  input  logic [31:0] wb_dat_miso,
  input  logic        wb_ack,
  input  logic        wb_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e        state;
  logic [CntW-1:0] cnt;

  assign req_ready = (state == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      wb_cyc      <= 1'b0;
      wb_stb      <= 1'b0;
      wb_we       <= 1'b0;
      wb_sel      <= '0;
      wb_adr      <= '0;
      wb_dat_mosi <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            wb_we       <= req_we;
            wb_adr      <= req_addr;
            wb_dat_mosi <= req_wdata;
            wb_sel      <= req_sel;
            wb_cyc      <= 1'b1;
            wb_stb      <= 1'b1;
            cnt         <= '0;
            state       <= StBus;
          end
        end
        StBus: begin
          // ack wins over err, err wins over timeout
          if (wb_ack) begin
            rsp_rdata   <= wb_we ? 32'h0 : wb_dat_miso;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
          end else if (wb_err) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b0;
          end else if (cnt == CntLast) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end
          if (wb_ack || wb_err || cnt == CntLast) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= StResp;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master_bridge.sv
// Directed bench for wishbone_master_bridge with a small registered slave at 0x100
// (err at 0x200, silent elsewhere).
module tb_wishbone_master_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_mosi;
  logic [31:0] wb_dat_miso;
  logic        wb_ack, wb_err;

  logic        s_ack = 1'b0, s_err = 1'b0, force_ack = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [31:0] mem = '0;
  int          ack_cnt = 0, cyc_cnt = 0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  wishbone_master_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
    .wb_dat_mosi(wb_dat_mosi), .wb_dat_miso(wb_dat_miso), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  assign wb_ack      = s_ack | force_ack;
  assign wb_err      = s_err;
  assign wb_dat_miso = s_rdata;

  // registered slave: responds one cycle after it sees cyc/stb
  always @(posedge clk) begin
    s_ack <= 1'b0;
    s_err <= 1'b0;
    if (wb_cyc) cyc_cnt <= cyc_cnt + 1;
    if (wb_ack) ack_cnt <= ack_cnt + 1;
    if (wb_cyc && wb_stb && !s_ack && !s_err) begin
      if (wb_adr == 32'h100) begin
        s_ack <= 1'b1;
        if (wb_we) begin
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) mem[b*8 +: 8] <= wb_dat_mosi[b*8 +: 8];
        end else begin
          s_rdata <= mem;
        end
      end else if (wb_adr == 32'h200) begin
        s_err <= 1'b1;
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_sel = sel; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // returns the number of negedges after accept until rsp_valid (0 if never)
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, rsp_timeout} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {req_ready, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, rsp_timeout});
    end
    total++;
    if ({wb_sel, wb_adr, wb_dat_mosi, rsp_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_data: sel=%h adr=%h dat=%h rdata=%h want all 0",
               wb_sel, wb_adr, wb_dat_mosi, rsp_rdata);
    end
  endtask

  task automatic test_write();
    int lat, a0, c0;
    a0 = ack_cnt; c0 = cyc_cnt;
    issue(1'b1, 32'h100, 32'h0000ABCD, 4'b0011);
    wait_rsp(lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL write_latency: got %0d want 3", lat); end
    total++;
    if ({rsp_err, rsp_timeout, rsp_rdata} !== 34'h0) begin
      bad++; $display("FAIL write_status: err=%b to=%b rdata=%h want 0/0/0", rsp_err, rsp_timeout,
                      rsp_rdata);
    end
    total++;
    if (ack_cnt - a0 != 1 || cyc_cnt - c0 != 2) begin
      bad++; $display("FAIL write_window: acks=%0d cyc=%0d want 1/2", ack_cnt - a0, cyc_cnt - c0);
    end
    total++;
    if (mem !== 32'h0000ABCD) begin bad++; $display("FAIL write_mem: got %h want 0000abcd", mem); end
    consume();
  endtask

  task automatic test_read();
    int lat, a0;
    logic prev_ack;
    a0 = ack_cnt; prev_ack = 1'b0; lat = 0;
    issue(1'b0, 32'h100, 32'h0, 4'b1111);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (prev_ack) begin
        total++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
          bad++; $display("FAIL read_cyc_drop: cyc=%b stb=%b want 0/0", wb_cyc, wb_stb);
        end
      end
      prev_ack = wb_ack;
      if (rsp_valid) begin lat = k; break; end
    end
    total++;
    if (lat != 3) begin bad++; $display("FAIL read_latency: got %0d want 3", lat); end
    total++;
    if (rsp_rdata !== 32'h0000ABCD || rsp_err !== 1'b0) begin
      bad++; $display("FAIL read_data: rdata=%h err=%b want 0000abcd/0", rsp_rdata, rsp_err);
    end
    total++;
    if (ack_cnt - a0 != 1) begin bad++; $display("FAIL read_acks: got %0d want 1", ack_cnt - a0); end
    consume();
  endtask

  task automatic test_slave_err();
    int lat;
    issue(1'b0, 32'h200, 32'h0, 4'b1111);
    wait_rsp(lat);
    total++;
    if (lat != 3 || {rsp_err, rsp_timeout, rsp_rdata} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL slave_err: lat=%0d err=%b to=%b rdata=%h want 3/1/0/0", lat, rsp_err,
                      rsp_timeout, rsp_rdata);
    end
    consume();
  endtask

  task automatic test_timeout();
    int lat, c0;
    c0 = cyc_cnt;
    issue(1'b0, 32'h300, 32'h0, 4'b1111);
    wait_rsp(lat);
    total++;
    if (cyc_cnt - c0 != 8) begin bad++; $display("FAIL timeout_window: got %0d want 8", cyc_cnt - c0); end
    total++;
    if (lat != 9 || {rsp_err, rsp_timeout, rsp_rdata} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL timeout_status: lat=%0d err=%b to=%b rdata=%h want 9/1/1/0", lat,
                      rsp_err, rsp_timeout, rsp_rdata);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(1'b1, 32'h100, 32'h12345678, 4'b1111);
    wait_rsp(lat);
    // second request held on req_valid while the response is stalled
    req_we = 1'b0; req_addr = 32'h100; req_sel = 4'b1111; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, req_ready, wb_cyc} !== {3'b100, 32'h0, 2'b00})
      begin
        bad++; $display("FAIL bp_hold[%0d]: valid=%b err=%b to=%b rdata=%h rdy=%b cyc=%b", k,
                        rsp_valid, rsp_err, rsp_timeout, rsp_rdata, req_ready, wb_cyc);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || wb_cyc !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: rdy=%b cyc=%b valid=%b want 1/0/0", req_ready, wb_cyc,
                      rsp_valid);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (wb_cyc !== 1'b1 || wb_we !== 1'b0 || wb_adr !== 32'h100) begin
      bad++; $display("FAIL bp_second_accept: cyc=%b we=%b adr=%h want 1/0/100", wb_cyc, wb_we,
                      wb_adr);
    end
    wait_rsp(lat);
    total++;
    if (lat != 2 || rsp_rdata !== 32'h12345678) begin
      bad++; $display("FAIL bp_second_read: lat=%0d rdata=%h want 2/12345678", lat, rsp_rdata);
    end
    consume();
  endtask

  task automatic test_reset_in_bus();
    issue(1'b0, 32'h300, 32'h0, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    total++;
    if ({wb_cyc, wb_stb, rsp_valid, req_ready} !== 4'b0001) begin
      bad++; $display("FAIL rst_bus: cyc=%b stb=%b valid=%b rdy=%b want 0/0/0/1", wb_cyc, wb_stb,
                      rsp_valid, req_ready);
    end
    @(posedge clk);
    #1 force_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({wb_cyc, rsp_valid, rsp_err, req_ready} !== 4'b0001) begin
        bad++; $display("FAIL rst_late_ack: cyc=%b valid=%b err=%b rdy=%b want 0/0/0/1", wb_cyc,
                        rsp_valid, rsp_err, req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_slave_err();
    test_timeout();
    test_backpressure();
    test_reset_in_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
